// File: rtl/btn_conditioner.sv
// N-channel debouncer for active-low push buttons: 2-flop sync, per-channel debounce FSM, level + strobes.
// Optional auto-repeat of the Press strobe is compiled in with BTN_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Key_n,
  output logic [N_BTN-1:0] Level,
  output logic [N_BTN-1:0] Press,
  output logic [N_BTN-1:0] Release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_WAIT   = 2'd3
  } state_t;

  if (N_BTN < 1) begin : g_bad_n_btn
    $error("btn_conditioner: N_BTN must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;

  // Two-flop synchroniser; inverts so that 1 means pressed from here on.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= ~Key_n;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            level_r;
    logic            level_s;
    logic            press_r;
    logic            press_s;
    logic            press_next_s;
    logic            rel_r;
    logic            rel_s;
    logic            smp_s;

    assign smp_s = sync2_r[i];

    // Debounce next-state: a change is accepted only after DEBOUNCE_CYCLES equal samples.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      level_s = level_r;
      press_s = 1'b0;
      rel_s   = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (smp_s) begin
            state_s = ST_PRESS_WAIT;
            cnt_s   = CNT_ONE;
          end else begin
            cnt_s   = CNT_ZERO;
          end
        end
        ST_PRESS_WAIT: begin
          if (!smp_s) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s = ST_HELD;
            cnt_s   = CNT_ZERO;
            level_s = 1'b1;
            press_s = 1'b1;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!smp_s) begin
            state_s = ST_REL_WAIT;
            cnt_s   = CNT_ONE;
          end else begin
            cnt_s   = CNT_ZERO;
          end
        end
        ST_REL_WAIT: begin
          if (smp_s) begin
            state_s = ST_HELD;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            level_s = 1'b0;
            rel_s   = 1'b1;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          level_s = 1'b0;
        end
      endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RPT_ZERO  = '0;
    localparam logic [RW-1:0] RPT_ONE   = RW'(1'b1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt_r;
    logic [RW-1:0] rpt_cnt_s;
    logic          rpt_first_r;
    logic          rpt_first_s;
    logic          rpt_fire_s;
    logic          enter_held_s;
    logic          enter_idle_s;

    // Repeat timer: runs through HELD and REL_WAIT (a release bounce does not restart it).
    always_comb begin
      enter_held_s = (state_r == ST_PRESS_WAIT) && (state_s == ST_HELD);
      enter_idle_s = (state_r == ST_REL_WAIT) && (state_s == ST_IDLE);
      rpt_cnt_s    = rpt_cnt_r;
      rpt_first_s  = rpt_first_r;
      rpt_fire_s   = 1'b0;
      if (enter_held_s) begin
        rpt_cnt_s   = RPT_ZERO;
        rpt_first_s = 1'b1;
      end else if (state_r == ST_HELD || state_r == ST_REL_WAIT) begin
        if (rpt_cnt_r == (rpt_first_r ? RPT_FIRST : RPT_NEXT)) begin
          rpt_cnt_s   = RPT_ZERO;
          rpt_first_s = 1'b0;
          rpt_fire_s  = !enter_idle_s;
        end else begin
          rpt_cnt_s   = rpt_cnt_r + RPT_ONE;
        end
      end else begin
        rpt_cnt_s   = RPT_ZERO;
        rpt_first_s = 1'b1;
      end
      press_next_s = press_s | rpt_fire_s;
    end

    // Repeat timer registers.
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        rpt_cnt_r   <= RPT_ZERO;
        rpt_first_r <= 1'b1;
      end else begin
        rpt_cnt_r   <= rpt_cnt_s;
        rpt_first_r <= rpt_first_s;
      end
    end
`else
    assign press_next_s = press_s;
`endif

    // Channel state and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        state_r <= ST_IDLE;
        cnt_r   <= CNT_ZERO;
        level_r <= 1'b0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        level_r <= level_s;
        press_r <= press_next_s;
        rel_r   <= rel_s;
      end
    end

    assign Level[i]   = level_r;
    assign Press[i]   = press_r;
    assign Release[i] = rel_r;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with N_BTN=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Step table feeds a scoreboard queue; hand sequences cover exact latency, reset mid-release and auto-repeat.
module tb_btn_conditioner;

  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic          Clk   = 1'b0;
  logic          Reset = 1'b1;
  logic [NB-1:0] Key_n = 2'b11;
  logic [NB-1:0] Level;
  logic [NB-1:0] Press;
  logic [NB-1:0] Release;

  always #5 Clk = ~Clk;

  btn_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Key_n(Key_n),
    .Level(Level), .Press(Press), .Release(Release)
  );

  typedef struct {
    logic [1:0] key_n;
    int         cycles;
    logic [1:0] level;
    int         press0;
    int         press1;
    int         rep0;
    int         rel0;
    int         rel1;
    string      name;
  } step_t;

  step_t tbl[9];
  step_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int press_cnt[NB];
  int rel_cnt[NB];
  int both_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    both_cnt = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      if (Press[i] === 1'b1) press_cnt[i]++;
      if (Release[i] === 1'b1) rel_cnt[i]++;
    end
    if ((Press & Release) != 2'b00) both_cnt++;
  endtask

  initial begin
    tbl[0] = '{2'b10, 8,  2'b01, 1, 0, 0, 0, 0, "ch0_press"};
    tbl[1] = '{2'b11, 8,  2'b00, 0, 0, 0, 1, 0, "ch0_release"};
    tbl[2] = '{2'b01, 3,  2'b00, 0, 0, 0, 0, 0, "bounce_lo1"};
    tbl[3] = '{2'b11, 2,  2'b00, 0, 0, 0, 0, 0, "bounce_hi1"};
    tbl[4] = '{2'b01, 3,  2'b00, 0, 0, 0, 0, 0, "bounce_lo2"};
    tbl[5] = '{2'b11, 10, 2'b00, 0, 0, 0, 0, 0, "bounce_end"};
    tbl[6] = '{2'b00, 8,  2'b11, 1, 1, 0, 0, 0, "both_press"};
    tbl[7] = '{2'b10, 8,  2'b01, 0, 0, 1, 0, 1, "ch1_release"};
    tbl[8] = '{2'b11, 8,  2'b00, 0, 0, 1, 1, 0, "ch0_release_late"};

    // Reset held with both keys pressed.
    #2;
    Reset = 1'b0;
    Key_n = 2'b00;
    clear_counts();
    repeat (3) tick();
    check("reset_level", int'(Level), 0);
    check("reset_press", int'(Press), 0);
    check("reset_release", int'(Release), 0);

    // Key held through reset: fresh debounce, Press on edge 6.
    Reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rst_rel_press_e%0d", e), int'(Press), (e == 6) ? 3 : 0);
      check($sformatf("rst_rel_level_e%0d", e), int'(Level), (e >= 6) ? 3 : 0);
    end

    // Release both: Release strobe on edge 6.
    Key_n = 2'b11;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rel_both_release_e%0d", e), int'(Release), (e == 6) ? 3 : 0);
      check($sformatf("rel_both_level_e%0d", e), int'(Level), (e >= 6) ? 0 : 3);
    end

    // Table-driven steps through the scoreboard.
    for (int s = 0; s < 9; s++) begin
      clear_counts();
      Key_n = tbl[s].key_n;
      sb_q.push_back(tbl[s]);
      for (int c = 0; c < tbl[s].cycles; c++) tick();
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        step_t ex;
        ex = sb_q.pop_front();
        check({ex.name, "_level"},  int'(Level), int'(ex.level));
        check({ex.name, "_press0"}, press_cnt[0], ex.press0 + AR * ex.rep0);
        check({ex.name, "_press1"}, press_cnt[1], ex.press1);
        check({ex.name, "_rel0"},   rel_cnt[0], ex.rel0);
        check({ex.name, "_rel1"},   rel_cnt[1], ex.rel1);
        check({ex.name, "_both"},   both_cnt, 0);
      end
    end

    // Reset while ch0 is in REL_WAIT with cnt=2.
    Key_n = 2'b10;
    repeat (8) tick();
    check("pre_rst_level", int'(Level), 1);
    Key_n = 2'b11;
    repeat (4) tick();
    check("relwait_level", int'(Level), 1);
    Reset = 1'b0;
    #1;
    check("mid_rst_level", int'(Level), 0);
    check("mid_rst_press", int'(Press), 0);
    check("mid_rst_release", int'(Release), 0);
    repeat (3) tick();
    Reset = 1'b1;
    clear_counts();
    repeat (12) tick();
    check("post_rst_rel0", rel_cnt[0], 0);
    check("post_rst_press0", press_cnt[0], 0);
    check("post_rst_level", int'(Level), 0);

    // ch0 held long: single Press, or Press at 6 then every repeat in the auto-repeat build.
    Key_n = 2'b10;
    for (int e = 1; e <= 36; e++) begin
      int exp_p;
      tick();
      exp_p = (e == 6 || (AR == 1 && e >= 6 + RD && ((e - 6 - RD) % RP) == 0)) ? 1 : 0;
      check($sformatf("hold_press0_e%0d", e), int'(Press[0]), exp_p);
    end
    check("hold_level", int'(Level), 1);
    Key_n = 2'b11;
    clear_counts();
    repeat (10) tick();
    check("hold_end_rel0", rel_cnt[0], 1);
    check("hold_end_level", int'(Level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
